// File: rtl/window_shift_reg_if.sv
// window_shift_reg_if: control, sample and window-output bundle
// shared between a sample source and window_shift_reg.
interface window_shift_reg_if #(
   parameter int WIDTH    = 37,
   parameter int DEPTH    = 5,
   parameter int CHANNELS = 1,
   parameter int SW       = WIDTH + $clog2(DEPTH) + 1
);
   localparam int FW = $clog2(DEPTH + 1);

   logic                            en;
   logic                            data_ready;
   logic                            clr;
   logic [CHANNELS*WIDTH-1:0]       din;
   logic [CHANNELS*DEPTH*WIDTH-1:0] dout;
   logic [CHANNELS*SW-1:0]          sum;
   logic [FW-1:0]                   fill;
   logic                            data_valid;
   logic                            win_strobe;

   modport master (
      output en, data_ready, clr, din,
      input  dout, sum, fill, data_valid, win_strobe
   );

   modport slave (
      input  en, data_ready, clr, din,
      output dout, sum, fill, data_valid, win_strobe
   );
endinterface

// File: rtl/window_shift_reg.sv
// window_shift_reg: multi-channel sliding window with fill tracking
// and a per-channel running sum of the current window.
module window_shift_reg #(
   parameter int WIDTH    = 37,
   parameter int DEPTH    = 5,
   parameter int CHANNELS = 1,
   parameter int SW       = WIDTH + $clog2(DEPTH) + 1
) (
   input logic               clk,
   input logic               rst,
   window_shift_reg_if.slave bus
);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FILLING,
      S_FULL
   } fill_state_t;

   fill_state_t   r_state, w_state_nxt;
   logic [FW-1:0] r_fill, w_fill_nxt;
   logic          r_dv, w_dv_nxt;
   logic          r_ws, w_ws_nxt;
   logic          w_acc, w_clr;

   logic signed [WIDTH-1:0] r_tap [CHANNELS][DEPTH];
   logic signed [SW-1:0]    r_sum [CHANNELS];
   logic signed [SW-1:0]    w_sum_nxt [CHANNELS];
   logic signed [WIDTH-1:0] w_din [CHANNELS];

   // clr wins over a same-cycle strobe; the sample is dropped
   assign w_clr = bus.en & bus.clr;
   assign w_acc = bus.en & bus.data_ready & ~bus.clr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EMPTY;
         r_fill  <= '0;
         r_dv    <= 1'b0;
         r_ws    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fill  <= w_fill_nxt;
         r_dv    <= w_dv_nxt;
         r_ws    <= w_ws_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_dv_nxt    = r_dv;
      w_ws_nxt    = 1'b0;
      unique case (1'b1)
         w_clr: begin
            w_state_nxt = S_EMPTY;
            w_fill_nxt  = '0;
            w_dv_nxt    = 1'b0;
         end
         w_acc: begin
            case (r_state)
               S_FULL: ;
               default: begin
                  w_fill_nxt  = r_fill + FW'(1);
                  w_state_nxt = (w_fill_nxt == FULL_CNT) ?
                                S_FULL : S_FILLING;
               end
            endcase
            w_dv_nxt = (w_state_nxt == S_FULL);
            w_ws_nxt = w_dv_nxt;
         end
         default: ;
      endcase
   end

   // unfilled taps hold 0, so the sum is exact before the window is full
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         w_sum_nxt[c] = r_sum[c] + SW'(w_din[c])
                        - SW'(r_tap[c][DEPTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c] <= '0;
            for (int k = 0; k < DEPTH; k++) r_tap[c][k] <= '0;
         end
      end else if (w_clr) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c] <= '0;
            for (int k = 0; k < DEPTH; k++) r_tap[c][k] <= '0;
         end
      end else if (w_acc) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c]    <= w_sum_nxt[c];
            r_tap[c][0] <= w_din[c];
            for (int k = 1; k < DEPTH; k++)
               r_tap[c][k] <= r_tap[c][k-1];
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign w_din[c] = bus.din[c*WIDTH +: WIDTH];
      assign bus.sum[c*SW +: SW] = r_sum[c];
      for (genvar k = 0; k < DEPTH; k++) begin : g_tap
         assign bus.dout[(c*DEPTH+k)*WIDTH +: WIDTH] = r_tap[c][k];
      end
   end

   assign bus.fill       = r_fill;
   assign bus.data_valid = r_dv;
   assign bus.win_strobe = r_ws;
endmodule

// File: doc/window_shift_reg.md
# window_shift_reg

Parametrised multi-channel sliding-window shift register with fill tracking and a running window sum. It is the generalised successor of the fixed 5-stage, single-channel delay line and feeds the feature-extraction stage, for example windowed energy or moving average, with DEPTH taps per channel. All channels share one sample strobe, and the block outputs every tap plus a per-channel signed sum of the current window.

## Interface
- WIDTH, default 37: signed sample width per channel.
- DEPTH, default 5: number of taps per channel. DEPTH ≥ 2.
- CHANNELS, default 1: number of parallel lanes that share the strobe. CHANNELS ≥ 1.
- SW, default WIDTH+$clog2(DEPTH)+1: width of the sum output.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when low, all state holds, including clr.
- data_ready  in  1  sample strobe; a sample is accepted when en && data_ready.
- clr  in  1  synchronous window flush; takes effect only when en is high.
- din  in  CHANNELS*WIDTH  signed samples; channel c occupies bits [c*WIDTH +: WIDTH].
- dout  out  CHANNELS*DEPTH*WIDTH  taps; tap k of channel c (k=0 newest) occupies bits [(c*DEPTH+k)*WIDTH +: WIDTH].
- sum  out  CHANNELS*SW  signed sum of the DEPTH taps per channel; channel c occupies bits [c*SW +: SW].
- fill  out  $clog2(DEPTH+1)  number of valid samples in the window; saturates at DEPTH.
- data_valid  out  1  level signal; high when fill == DEPTH.
- win_strobe  out  1  one-cycle pulse after each accepted sample that leaves the window full.

## Operation
- All outputs are registered and reset to 0. This covers every tap, sum, fill, data_valid and win_strobe.
- Accept (en && data_ready && !clr), per channel:
  - tap0 <= din
  - tap k <= tap k-1
  - sum <= sum + sext(din) - sext(tap DEPTH-1)
  - fill <= min(fill+1, DEPTH)
- Incremental sum:
  - Unfilled taps are 0, so the subtracted oldest value is 0 until the window is full. The sum is therefore exact from the first sample.
  - Arithmetic is two's complement at SW bits with sign-extended operands. With the default SW no overflow is possible.
- clr with en high:
  - Zeroes all taps, sum, fill, data_valid and win_strobe on the next edge.
  - clr has priority over a simultaneous data_ready; that sample is dropped.
- en low: complete freeze. win_strobe is forced to 0.
- win_strobe <= accept && (next fill == DEPTH). It is 0 in all other cycles.
- data_valid <= (next fill == DEPTH). Once high, it stays high until clr or rst.
- Fill counter states: EMPTY (0), FILLING (1..DEPTH-1), FULL (DEPTH).
  - Accept moves up one state. In FULL, accept stays FULL.
  - clr from any state goes to EMPTY. rst from any state goes to EMPTY asynchronously.
- Channels are independent datapaths that share the control path; fill and data_valid are common to all channels.

## Timing
- Latency is 1 cycle from the accepting edge. Tap0, sum and fill reflect the sample accepted on that edge.
- The sample accepted at edge n appears at tap k after edge n+k, counting accepted edges only. Stalls, meaning data_ready low, insert no bubbles.
- data_valid first rises on the edge that accepts sample number DEPTH after reset or clr.
- Back-to-back accepts are supported, one per cycle. There is no backpressure output; the upstream block must not drive data_ready while en is low if it requires the sample to be kept.
- rst assertion mid-stream clears all outputs immediately, without waiting for a clock.
- Release of rst is synchronous to the system; the first accept is possible on the first edge after release.

## Test plan
- Defaults (WIDTH=37, DEPTH=5, CHANNELS=1). After rst release, strobe din=100,200,…,900 on consecutive cycles.
  - After the 5th sample: taps 500,400,300,200,100; sum=1500; fill=5; data_valid=1; win_strobe=1.
  - After the 9th sample: taps 900..500; sum=3500.
  - data_valid=0 and sum is exact (100, 300, 600, 1000) during samples 1–4.
- Stall: load 100,200,300, hold data_ready=0 for 3 cycles, then load 400.
  - Taps and sum do not move during the stall.
  - Final taps 400,300,200,100,0; sum=1000; fill=4; win_strobe never pulses.
- Negative values: load -1, -2^36, 5, 7, -3.
  - sum = -2^36+8.
  - Loading the next value 10 gives sum = -2^36+19.
  - The sign is held in the SW-bit output.
- clr and en interaction:
  - Assert clr together with data_ready=1 while full: all outputs are 0 next cycle and the sample is dropped.
  - clr with en=0: no effect.
- Asynchronous reset mid-stream: drop rst between clock edges when fill=3. All outputs read 0 before the next rising edge.
- CHANNELS=2, DEPTH=4: drive ch0 = 1,2,3,4 and ch1 = -1,-2,-3,-4.
  - sum: ch0=10, ch1=-10.
  - Tap ordering in dout matches the slice mapping defined in the Interface section.
